// File: rtl/debounce_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and the
// default stability window for a 25 MHz clock.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    HELD    = 2'd2,
    FILT_UP = 2'd3
  } state_t;

  localparam int CNT_MAX_20MS = 500_000;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with a synchronous active-low reset
// that parks both flops at RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= {2{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low key: synchroniser, stability counter and a
// four-state filter FSM driving a clean level, press/release pulses and a toggle.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_20MS,
  parameter int CNT_W   = 20
) (
  input  logic ext_clk_25m,
  input  logic ext_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             s_key;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             toggle_reg, toggle_next;
  logic             accept_dn, accept_up;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (ext_clk_25m),
    .rst_n(ext_rst_n),
    .d    (key_in),
    .q    (s_key)
  );

  // A flip of s_key on the terminal count takes priority, so acceptance
  // requires the filtered level to still hold on that very cycle.
  assign accept_dn = (state_reg == FILT_DN) && !s_key && (counter_reg == CNT_LAST);
  assign accept_up = (state_reg == FILT_UP) &&  s_key && (counter_reg == CNT_LAST);

  always_ff @(posedge ext_clk_25m) begin
    if (!ext_rst_n) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      level_reg   <= 1'b1;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      toggle_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      toggle_reg  <= toggle_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      IDLE: begin
        if (!s_key) begin
          state_next   = FILT_DN;
          counter_next = '0;
        end
      end
      FILT_DN: begin
        if (s_key) begin
          state_next   = IDLE;
          counter_next = '0;
        end else if (counter_reg == CNT_LAST) begin
          state_next   = HELD;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (s_key) begin
          state_next   = FILT_UP;
          counter_next = '0;
        end
      end
      FILT_UP: begin
        if (!s_key) begin
          state_next   = HELD;
          counter_next = '0;
        end else if (counter_reg == CNT_LAST) begin
          state_next   = IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_comb begin
    level_next   = level_reg;
    press_next   = accept_dn;
    release_next = accept_up;
    toggle_next  = toggle_reg ^ accept_dn;
    if (accept_dn) begin
      level_next = 1'b0;
    end else if (accept_up) begin
      level_next = 1'b1;
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
  assign key_toggle  = toggle_reg;

endmodule
